neuron08_array: RTL and testbench

Time-multiplexed array of adaptive leaky-integrate-and-fire neurons. One shared update datapath sweeps `N_NEURONS` neuron states once per simulation time step. Each neuron has input accumulation, exponential decay, adaptive threshold, adaptive resting voltage and absolute refractory. All arithmetic saturates instead of wrapping. The block sits between the synaptic-input stage, which supplies per-neuron input on request, and the spike-routing stage, which consumes the spike vector.

---
 rtl/neuron08_array_if.sv | 33 +++
 rtl/neuron08_array.sv | 188 ++++++++++++++++++
 tb/tb_neuron08_array.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/neuron08_array_if.sv
// Bus bundle for neuron08_array: step/done handshake, per-neuron input request,
// spike vector, overrun flag and the state monitor.
//   slave  : the neuron array itself
//   master : the controlling side (input stage, spike router, monitor)
interface neuron08_array_if #(
  parameter int unsigned DATA_LENGTH = 16,
  parameter int unsigned N_NEURONS   = 4,
  parameter int unsigned IDX_WIDTH   = 2
) ();
  logic                   i_step;
  logic                   o_busy;
  logic [IDX_WIDTH-1:0]   o_in_idx;
  logic [DATA_LENGTH-1:0] i_in_data;
  logic [N_NEURONS-1:0]   o_spike_vec;
  logic                   o_done;
  logic                   o_overrun;
  logic [IDX_WIDTH-1:0]   i_mon_idx;
  logic [DATA_LENGTH-1:0] o_int_vol;
  logic [DATA_LENGTH-1:0] o_thr_vol;
  logic [DATA_LENGTH-1:0] o_rst_vol;

  modport slave (
    input  i_step, i_in_data, i_mon_idx,
    output o_busy, o_in_idx, o_spike_vec, o_done, o_overrun,
           o_int_vol, o_thr_vol, o_rst_vol
  );

  modport master (
    output i_step, i_in_data, i_mon_idx,
    input  o_busy, o_in_idx, o_spike_vec, o_done, o_overrun,
           o_int_vol, o_thr_vol, o_rst_vol
  );
endinterface

// File: rtl/neuron08_array.sv
// Time-multiplexed array of adaptive leaky-integrate-and-fire neurons. One shared
// datapath updates one neuron per cycle; a pulse on i_step sweeps all N_NEURONS.
// Ports:
//   i_clk, i_rst : clock, asynchronous active-high reset
//   bus (slave)  : i_step / o_busy / o_done / o_overrun handshake, o_in_idx +
//                  i_in_data input request, o_spike_vec, i_mon_idx -> o_*_vol monitor
module neuron08_array #(
  parameter int unsigned DATA_LENGTH   = 16,
  parameter int unsigned N_NEURONS     = 4,
  parameter int unsigned IDX_WIDTH     = 2,
  parameter int unsigned TAU_BUF_SHIFT = 2,
  parameter int unsigned TAU_INT_SHIFT = 4,
  parameter int unsigned TAU_THR_SHIFT = 5,
  parameter int unsigned TAU_RST_SHIFT = 6,
  parameter int unsigned MAX_THR       = 49152,
  parameter int unsigned MIN_THR       = 32768,
  parameter int unsigned THR_CONTRIB   = 4096,
  parameter int unsigned MAX_RST       = 8192,
  parameter int unsigned MIN_RST       = 0,
  parameter int unsigned RST_CONTRIB   = 2048,
  parameter int unsigned REFRAC_STEPS  = 3,
  parameter bit          DECAY_EN      = 1'b1
) (
  input logic              i_clk,
  input logic              i_rst,
  neuron08_array_if.slave  bus
);
  localparam int unsigned DL   = DATA_LENGTH;
  localparam int unsigned W    = DATA_LENGTH + 2;
  localparam int unsigned RefW = (REFRAC_STEPS > 0) ? $clog2(REFRAC_STEPS + 1) : 1;

  localparam logic [DL-1:0] DMax       = '1;
  localparam logic [DL-1:0] MaxThr     = DL'(MAX_THR);
  localparam logic [DL-1:0] MinThr     = DL'(MIN_THR);
  localparam logic [DL-1:0] ThrContrib = DL'(THR_CONTRIB);
  localparam logic [DL-1:0] MaxRst     = DL'(MAX_RST);
  localparam logic [DL-1:0] MinRst     = DL'(MIN_RST);
  localparam logic [DL-1:0] RstContrib = DL'(RST_CONTRIB);
  localparam logic [IDX_WIDTH-1:0] LastIdx = IDX_WIDTH'(N_NEURONS - 1);

  typedef enum logic [1:0] {StIdle, StSweep, StDone} state_e;

  function automatic logic signed [W-1:0] ext(input logic [DL-1:0] x);
    return $signed({2'b00, x});
  endfunction

  // Clamp a wide signed intermediate into [0, 2^DL-1].
  function automatic logic [DL-1:0] sat(input logic signed [W-1:0] v);
    if (v[W-1]) return '0;
    else if (v > ext(DMax)) return DMax;
    else return v[DL-1:0];
  endfunction

  state_e                 state_q, state_d;
  logic [IDX_WIDTH-1:0]   idx_q, idx_d;
  logic                   overrun_q, overrun_d;
  logic [N_NEURONS-1:0]   spike_q, spike_d;
  logic                   upd_en;

  logic [DL-1:0]   buf_vol_q [N_NEURONS];
  logic [DL-1:0]   int_vol_q [N_NEURONS];
  logic [DL-1:0]   thr_vol_q [N_NEURONS];
  logic [DL-1:0]   rst_vol_q [N_NEURONS];
  logic [RefW-1:0] refr_q    [N_NEURONS];

  logic [DL-1:0]   cur_buf, cur_int, cur_thr, cur_rst;
  logic [RefW-1:0] cur_refr;
  logic            fire;
  logic [DL-1:0]   buf_d, int_d, thr_d, rst_d, inp, dec_mag;
  logic [RefW-1:0] refr_d;
  logic signed [W-1:0] rst_sub, thr_add;

  assign cur_buf  = buf_vol_q[idx_q];
  assign cur_int  = int_vol_q[idx_q];
  assign cur_thr  = thr_vol_q[idx_q];
  assign cur_rst  = rst_vol_q[idx_q];
  assign cur_refr = refr_q[idx_q];
  assign fire     = (cur_int >= cur_thr);

  // Next state of the neuron currently selected by idx_q, from its old values only.
  always_comb begin
    buf_d   = cur_buf;
    int_d   = cur_int;
    thr_d   = cur_thr;
    rst_d   = cur_rst;
    refr_d  = cur_refr;
    inp     = '0;
    rst_sub = ext(cur_rst) - ext(RstContrib);
    thr_add = ext(cur_thr) + ext(ThrContrib);
    dec_mag = (cur_rst >= cur_int) ? ((cur_rst - cur_int) >> TAU_INT_SHIFT)
                                   : ((cur_int - cur_rst) >> TAU_INT_SHIFT);
    if (!DECAY_EN) dec_mag = '0;

    if (fire) begin
      int_d  = sat(rst_sub);
      rst_d  = (rst_sub < ext(MinRst)) ? MinRst : rst_sub[DL-1:0];
      thr_d  = (thr_add > ext(MaxThr)) ? MaxThr : thr_add[DL-1:0];
      refr_d = RefW'(REFRAC_STEPS);
      buf_d  = '0;
    end else begin
      if (|cur_refr) begin
        // Refractory: input is discarded, not buffered for later.
        refr_d = cur_refr - RefW'(1);
        buf_d  = '0;
      end else begin
        inp   = cur_buf >> TAU_BUF_SHIFT;
        buf_d = sat(ext(cur_buf) + ext(bus.i_in_data) - ext(inp));
      end
      int_d = sat((cur_rst >= cur_int) ? (ext(cur_int) + ext(dec_mag) + ext(inp))
                                       : (ext(cur_int) - ext(dec_mag) + ext(inp)));
      thr_d = cur_thr - ((cur_thr > MinThr) ? ((cur_thr - MinThr) >> TAU_THR_SHIFT) : '0);
      rst_d = cur_rst + ((cur_rst < MaxRst) ? ((MaxRst - cur_rst) >> TAU_RST_SHIFT) : '0);
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    overrun_d = overrun_q;
    upd_en    = 1'b0;
    if (bus.i_step && (state_q != StIdle)) overrun_d = 1'b1;
    unique case (state_q)
      StIdle: begin
        if (bus.i_step) begin
          state_d = StSweep;
          idx_d   = '0;
        end
      end
      StSweep: begin
        upd_en = 1'b1;
        if (idx_q == LastIdx) begin
          state_d = StDone;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + IDX_WIDTH'(1);
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    spike_d = spike_q;
    if (upd_en) spike_d[idx_q] = fire;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= StIdle;
      idx_q     <= '0;
      overrun_q <= 1'b0;
      spike_q   <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      overrun_q <= overrun_d;
      spike_q   <= spike_d;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int n = 0; n < int'(N_NEURONS); n++) begin
        buf_vol_q[n] <= '0;
        int_vol_q[n] <= MaxRst;
        thr_vol_q[n] <= MinThr;
        rst_vol_q[n] <= MaxRst;
        refr_q[n]    <= '0;
      end
    end else if (upd_en) begin
      buf_vol_q[idx_q] <= buf_d;
      int_vol_q[idx_q] <= int_d;
      thr_vol_q[idx_q] <= thr_d;
      rst_vol_q[idx_q] <= rst_d;
      refr_q[idx_q]    <= refr_d;
    end
  end

  assign bus.o_busy      = (state_q != StIdle);
  assign bus.o_done      = (state_q == StDone);
  assign bus.o_in_idx    = idx_q;
  assign bus.o_spike_vec = spike_q;
  assign bus.o_overrun   = overrun_q;
  assign bus.o_int_vol   = int_vol_q[bus.i_mon_idx];
  assign bus.o_thr_vol   = thr_vol_q[bus.i_mon_idx];
  assign bus.o_rst_vol   = rst_vol_q[bus.i_mon_idx];
endmodule

// File: tb/tb_neuron08_array.sv
// Bench for neuron08_array: a leaky instance (ifa) and a perfect-integrator
// instance (ifb, DECAY_EN = 0) share clock and reset.
module tb_neuron08_array;
  logic clk;
  logic rst;
  int   total;
  int   bad;

  logic [1:0]  feed_idx;
  logic [15:0] feed_val;

  neuron08_array_if #(.DATA_LENGTH(16), .N_NEURONS(4), .IDX_WIDTH(2)) ifa ();
  neuron08_array_if #(.DATA_LENGTH(16), .N_NEURONS(4), .IDX_WIDTH(2)) ifb ();

  neuron08_array u_dut_a (.i_clk(clk), .i_rst(rst), .bus(ifa));
  neuron08_array #(.DECAY_EN(1'b0)) u_dut_b (.i_clk(clk), .i_rst(rst), .bus(ifb));

  // Upstream drives input combinationally for the requested neuron.
  assign ifa.i_in_data = (ifa.o_in_idx == feed_idx) ? feed_val : 16'd0;
  assign ifb.i_in_data = (ifb.o_in_idx == 2'd0) ? 16'd400 : 16'd0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not reach summary");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [3:0]  spk;
    logic [15:0] iv;
    logic [15:0] tv;
    logic [15:0] rv;
  } vec_t;

  vec_t tbl [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Pulse i_step; return cycles until o_done (20 = timed out). Ends in the done cycle.
  task automatic step_a(output int lat);
    @(negedge clk) ifa.i_step = 1'b1;
    @(negedge clk) ifa.i_step = 1'b0;
    lat = 1;
    while (!ifa.o_done && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic step_b(output int lat);
    @(negedge clk) ifb.i_step = 1'b1;
    @(negedge clk) ifb.i_step = 1'b0;
    lat = 1;
    while (!ifb.o_done && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask

  initial begin
    int lat;
    int n;
    int dcnt;
    int dcyc;
    int prev;
    bit spiked;

    total = 0;
    bad   = 0;
    // Neuron 1 driven at 65535 every step: hand-computed trajectory.
    tbl[0] = '{4'b0000,  8192, 32768, 8192};
    tbl[1] = '{4'b0000, 24575, 32768, 8192};
    tbl[2] = '{4'b0000, 39935, 32768, 8192};
    tbl[3] = '{4'b0010,  6144, 36864, 6144};
    tbl[4] = '{4'b0000,  6144, 36736, 6176};
    tbl[5] = '{4'b0000,  6146, 36612, 6207};
    tbl[6] = '{4'b0000,  6149, 36492, 6238};
    tbl[7] = '{4'b0000,  6154, 36376, 6268};
    tbl[8] = '{4'b0000, 22544, 36264, 6298};

    rst = 1'b1;
    ifa.i_step = 1'b0;
    ifb.i_step = 1'b0;
    ifa.i_mon_idx = 2'd0;
    ifb.i_mon_idx = 2'd0;
    feed_idx = 2'd1;
    feed_val = 16'd0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset state
    chk("rst_busy", ifa.o_busy, 0);
    chk("rst_done", ifa.o_done, 0);
    chk("rst_spike", ifa.o_spike_vec, 0);
    chk("rst_overrun", ifa.o_overrun, 0);
    chk("rst_idx", ifa.o_in_idx, 0);
    for (int m = 0; m < 4; m++) begin
      ifa.i_mon_idx = 2'(m);
      #1;
      chk("rst_int", ifa.o_int_vol, 8192);
      chk("rst_thr", ifa.o_thr_vol, 32768);
      chk("rst_rstv", ifa.o_rst_vol, 8192);
    end

    // Zero input for 20 steps: nothing moves
    for (int s = 0; s < 20; s++) begin
      step_a(lat);
      chk("zero_latency", 32'(lat), 5);
      chk("zero_spike", ifa.o_spike_vec, 0);
    end
    for (int m = 0; m < 4; m++) begin
      ifa.i_mon_idx = 2'(m);
      #1;
      chk("zero_int", ifa.o_int_vol, 8192);
      chk("zero_thr", ifa.o_thr_vol, 32768);
    end

    // Saturating drive on neuron 1
    feed_idx = 2'd1;
    feed_val = 16'hFFFF;
    ifa.i_mon_idx = 2'd1;
    for (int s = 0; s < 9; s++) begin
      step_a(lat);
      chk("drv_latency", 32'(lat), 5);
      chk("drv_spike", ifa.o_spike_vec, tbl[s].spk);
      chk("drv_int", ifa.o_int_vol, tbl[s].iv);
      chk("drv_thr", ifa.o_thr_vol, tbl[s].tv);
      chk("drv_rstv", ifa.o_rst_vol, tbl[s].rv);
    end
    ifa.i_mon_idx = 2'd0;
    #1;
    chk("drv_other_int", ifa.o_int_vol, 8192);
    feed_val = 16'd0;

    // Overrun: second step pulse during the sweep
    @(negedge clk) ifa.i_step = 1'b1;
    @(negedge clk) ifa.i_step = 1'b0;
    chk("ovr_busy_first", ifa.o_busy, 1);
    chk("ovr_idx_first", ifa.o_in_idx, 0);
    chk("ovr_clear_before", ifa.o_overrun, 0);
    @(negedge clk);
    chk("ovr_idx_second", ifa.o_in_idx, 1);
    ifa.i_step = 1'b1;
    @(negedge clk) ifa.i_step = 1'b0;
    chk("ovr_set", ifa.o_overrun, 1);
    dcnt = 0;
    dcyc = 0;
    for (int c = 3; c < 12; c++) begin
      if (ifa.o_done) begin
        dcnt++;
        dcyc = c;
      end
      if (c == 5) chk("ovr_busy_in_done", ifa.o_busy, 1);
      if (c == 6) chk("ovr_busy_after", ifa.o_busy, 0);
      @(negedge clk);
    end
    chk("ovr_done_count", 32'(dcnt), 1);
    chk("ovr_done_cycle", 32'(dcyc), 5);
    chk("ovr_sticky", ifa.o_overrun, 1);

    // Asynchronous reset mid-sweep
    ifa.i_mon_idx = 2'd1;
    @(negedge clk) ifa.i_step = 1'b1;
    @(negedge clk) ifa.i_step = 1'b0;
    n = 0;
    while (ifa.o_in_idx != 2'd2 && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("arst_reach_idx2", ifa.o_in_idx, 2);
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", ifa.o_busy, 0);
    chk("arst_idx", ifa.o_in_idx, 0);
    chk("arst_done", ifa.o_done, 0);
    chk("arst_overrun", ifa.o_overrun, 0);
    chk("arst_spike", ifa.o_spike_vec, 0);
    chk("arst_int", ifa.o_int_vol, 8192);
    chk("arst_thr", ifa.o_thr_vol, 32768);
    chk("arst_rstv", ifa.o_rst_vol, 6144 + 2048);
    @(negedge clk);
    @(negedge clk) rst = 1'b0;
    dcnt = 0;
    for (int c = 0; c < 8; c++) begin
      if (ifa.o_done) dcnt++;
      @(negedge clk);
    end
    chk("arst_no_done", 32'(dcnt), 0);
    step_a(lat);
    chk("arst_fresh_latency", 32'(lat), 5);
    chk("arst_fresh_spike", ifa.o_spike_vec, 0);

    // Perfect integrator, neuron 0 fed 400 per step
    prev = 8192;
    spiked = 1'b0;
    for (int s = 1; s <= 150 && !spiked; s++) begin
      step_b(lat);
      chk("b_latency", 32'(lat), 5);
      if (ifb.o_spike_vec[0]) begin
        spiked = 1'b1;
        chk("b_fire_at_thr", 32'(prev >= 32768), 1);
        chk("b_fire_int", ifb.o_int_vol, 6144);
        chk("b_fire_thr", ifb.o_thr_vol, 36864);
      end else begin
        chk("b_nofire_below", 32'(prev < 32768), 1);
        if (s == 1) chk("b_int_s1", ifb.o_int_vol, 8192);
        if (s == 2) chk("b_int_s2", ifb.o_int_vol, 8292);
        if (s == 3) chk("b_int_s3", ifb.o_int_vol, 8467);
        if (s >= 2) chk("b_rise", 32'(int'(ifb.o_int_vol) > prev), 1);
        prev = int'(ifb.o_int_vol);
      end
    end
    chk("b_spiked", 32'(spiked), 1);
    step_b(lat);
    chk("b_thr_decay1", ifb.o_thr_vol, 36736);
    step_b(lat);
    chk("b_thr_decay2", ifb.o_thr_vol, 36612);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
